// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory read arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } arb_state_e;

    localparam logic MASTER_DEMAND   = 1'b0;
    localparam logic MASTER_PREFETCH = 1'b1;

    localparam int unsigned ARID_WIDTH = 4;
    localparam logic [ARID_WIDTH-1:0] ARID_DEMAND   = 4'd0;
    localparam logic [ARID_WIDTH-1:0] ARID_PREFETCH = 4'd1;

    function automatic logic [ARID_WIDTH-1:0] arid_of(input logic owner);
        return (owner == MASTER_PREFETCH) ? ARID_PREFETCH : ARID_DEMAND;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the memory read channel.
interface mem_read_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 5
);
    logic [ADDR_WIDTH-1:0] m0_araddr;
    logic [LEN_WIDTH-1:0]  m0_arlen;
    logic                  m0_arvalid;
    logic                  m0_arready;
    logic                  m0_rvalid;
    logic                  m0_rlast;
    logic [ADDR_WIDTH-1:0] m1_araddr;
    logic [LEN_WIDTH-1:0]  m1_arlen;
    logic                  m1_arvalid;
    logic                  m1_arready;
    logic                  m1_rvalid;
    logic                  m1_rlast;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] mem_araddr;
    logic [LEN_WIDTH-1:0]  mem_arlen;
    logic                  mem_arvalid;
    logic                  mem_arready;
    logic [ARID_WIDTH-1:0] mem_arid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_rvalid;
    logic                  mem_rready;

    // Arbiter side.
    modport slave (
        input  m0_araddr, m0_arlen, m0_arvalid, m1_araddr, m1_arlen, m1_arvalid,
               mem_arready, mem_rdata, mem_rvalid,
        output m0_arready, m0_rvalid, m0_rlast, m1_arready, m1_rvalid, m1_rlast, r_data,
               mem_araddr, mem_arlen, mem_arvalid, mem_arid, mem_rready
    );

    // Requester and memory side.
    modport master (
        output m0_araddr, m0_arlen, m0_arvalid, m1_araddr, m1_arlen, m1_arvalid,
               mem_arready, mem_rdata, mem_rvalid,
        input  m0_arready, m0_rvalid, m0_rlast, m1_arready, m1_rvalid, m1_rlast, r_data,
               mem_araddr, mem_arlen, mem_arvalid, mem_arid, mem_rready
    );

endinterface

// File: rtl/mem_read_arbiter.sv
// Shares one memory read channel between i-cache demand refill (m0) and the prefetcher (m1);
// demand wins unless the prefetcher has been passed over STARVE_LIMIT times in a row.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LEN_WIDTH    = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_read_arbiter_if.slave bus
);
    localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [StarveW-1:0]    starve_q, starve_d;

    logic                  grant_valid;
    logic                  grant_m1;
    logic [LEN_WIDTH-1:0]  grant_len_raw;
    logic                  last_beat;

    assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= MASTER_DEMAND;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        len_d         = len_q;
        beat_d        = beat_q;
        starve_d      = starve_q;
        grant_valid   = bus.m0_arvalid || bus.m1_arvalid;
        grant_m1      = bus.m1_arvalid &&
                        (!bus.m0_arvalid || (starve_q == StarveW'(STARVE_LIMIT)));
        grant_len_raw = grant_m1 ? bus.m1_arlen : bus.m0_arlen;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    owner_d = grant_m1 ? MASTER_PREFETCH : MASTER_DEMAND;
                    addr_d  = grant_m1 ? bus.m1_araddr : bus.m0_araddr;
                    // A zero-length request still moves one beat.
                    len_d   = (grant_len_raw == '0) ? LEN_WIDTH'(1) : grant_len_raw;
                    state_d = StAddr;
                end
                if (!bus.m1_arvalid || grant_m1) begin
                    starve_d = '0;
                end else if (starve_q != StarveW'(STARVE_LIMIT)) begin
                    starve_d = starve_q + StarveW'(1);
                end
            end
            StAddr: begin
                if (bus.mem_arready) begin
                    state_d = StData;
                    beat_d  = '0;
                end
            end
            StData: begin
                if (bus.mem_rvalid) begin
                    beat_d = beat_q + LEN_WIDTH'(1);
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.mem_arvalid = (state_q == StAddr);
        bus.mem_araddr  = addr_q;
        bus.mem_arlen   = len_q;
        bus.mem_arid    = arid_of(owner_q);
        bus.mem_rready  = 1'b1;
        bus.r_data      = DATA_WIDTH'(bus.mem_rdata);
        bus.m0_arready  = bus.mem_arvalid && (owner_q == MASTER_DEMAND) && bus.mem_arready;
        bus.m1_arready  = bus.mem_arvalid && (owner_q == MASTER_PREFETCH) && bus.mem_arready;
        bus.m0_rvalid   = (state_q == StData) && (owner_q == MASTER_DEMAND) && bus.mem_rvalid;
        bus.m1_rvalid   = (state_q == StData) && (owner_q == MASTER_PREFETCH) && bus.mem_rvalid;
        bus.m0_rlast    = bus.m0_rvalid && last_beat;
        bus.m1_rlast    = bus.m1_rvalid && last_beat;
    end

`ifdef SIMULATION
    // MemArb_demand_grant / MemArb_prefetch_grant / MemArb_prefetch_stall
    logic [31:0] memarb_demand_grant_q;
    logic [31:0] memarb_prefetch_grant_q;
    logic [31:0] memarb_prefetch_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            memarb_demand_grant_q   <= '0;
            memarb_prefetch_grant_q <= '0;
            memarb_prefetch_stall_q <= '0;
        end else begin
            if (state_q == StIdle && grant_valid && !grant_m1) begin
                memarb_demand_grant_q <= memarb_demand_grant_q + 32'd1;
            end
            if (state_q == StIdle && grant_m1) begin
                memarb_prefetch_grant_q <= memarb_prefetch_grant_q + 32'd1;
            end
            if (bus.m1_arvalid && !(state_q == StIdle && grant_m1) &&
                !(state_q == StAddr && owner_q == MASTER_PREFETCH)) begin
                memarb_prefetch_stall_q <= memarb_prefetch_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(state_q == StIdle && grant_valid && grant_len_raw == '0))
            else $warning("mem_read_arbiter: arlen=0 granted, treated as 1 beat");
            assert (!(state_q != StData && bus.mem_rvalid))
            else $warning("mem_read_arbiter: mem_rvalid outside a data phase ignored");
        end
    end
`endif

endmodule
